// File: rtl/oc8051_int_seq_if.sv
// Sequencer <-> core/controller/stack-RAM signal bundle; master is the sequencer side,
// slave is the core side that raises requests and answers stack accesses.
interface oc8051_int_seq_if;
    logic        intr;
    logic [7:0]  int_vec;
    logic        instr_end;
    logic        reti_instr;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic        stk_rdy;
    logic [7:0]  stk_rdata;
    logic        ack;
    logic        reti;
    logic        stall;
    logic        pc_ld;
    logic [15:0] pc_out;
    logic        stk_we;
    logic        stk_re;
    logic [7:0]  stk_addr;
    logic [7:0]  stk_wdata;
    logic        sp_we;
    logic [7:0]  sp_out;

    modport master (
        input  intr, int_vec, instr_end, reti_instr, pc, sp, stk_rdy, stk_rdata,
        output ack, reti, stall, pc_ld, pc_out, stk_we, stk_re, stk_addr, stk_wdata, sp_we, sp_out
    );

    modport slave (
        output intr, int_vec, instr_end, reti_instr, pc, sp, stk_rdy, stk_rdata,
        input  ack, reti, stall, pc_ld, pc_out, stk_we, stk_re, stk_addr, stk_wdata, sp_we, sp_out
    );
endinterface

// File: rtl/oc8051_int_seq.sv
// Interrupt entry/return sequencer: ack 2 cycles after intr at a boundary, PC load 3 cycles later; RETI reload in 3.
// Each stack access waits on stk_rdy with request outputs held stable; only sp_we follows stk_rdy combinationally.
module oc8051_int_seq (
    input  logic             clk,
    input  logic             rst,
    oc8051_int_seq_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, PEND, ACK, PUSH_L, PUSH_H, LOAD, POP_H, POP_L, RET
    } state_t;

    state_t      state_q, state_d;
    logic        pend_q, inhibit_q;
    logic [7:0]  vec_q, sp_q, pch_q, pcl_q;
    logic [15:0] pc_q;
    logic [7:0]  sp_inc, sp_dec;
    logic        boundary;

    assign sp_inc   = sp_q + 8'd1;
    assign sp_dec   = sp_q - 8'd1;
    assign boundary = (state_q == IDLE) || (state_q == PEND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // RETI is checked before interrupt entry so a simultaneous intr stays pending behind the return.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.reti_instr)                   state_d = POP_H;
                     else if (pend_q || bus.intr)          state_d = PEND;
            PEND:    if (bus.reti_instr)                   state_d = POP_H;
                     else if (bus.instr_end && !inhibit_q) state_d = ACK;
            ACK:     state_d = PUSH_L;
            PUSH_L:  if (bus.stk_rdy) state_d = PUSH_H;
            PUSH_H:  if (bus.stk_rdy) state_d = LOAD;
            LOAD:    state_d = IDLE;
            POP_H:   if (bus.stk_rdy) state_d = POP_L;
            POP_L:   if (bus.stk_rdy) state_d = RET;
            RET:     state_d = pend_q ? PEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= 1'b0;
            inhibit_q <= 1'b0;
            vec_q     <= 8'h00;
            sp_q      <= 8'h00;
            pch_q     <= 8'h00;
            pcl_q     <= 8'h00;
            pc_q      <= 16'h0000;
        end else begin
            // A later pulse simply replaces the latched vector (level-1 preemption).
            if (bus.intr) vec_q <= bus.int_vec;
            if (state_d == ACK) pend_q <= 1'b0;
            else if (bus.intr)  pend_q <= 1'b1;
            if (state_q == RET)                    inhibit_q <= 1'b1;
            else if (boundary && bus.instr_end)    inhibit_q <= 1'b0;
            case (state_q)
                IDLE, PEND: if (bus.reti_instr) sp_q <= bus.sp;
                ACK: begin
                    pc_q <= bus.pc;
                    sp_q <= bus.sp;
                end
                PUSH_L, PUSH_H: if (bus.stk_rdy) sp_q <= sp_inc;
                POP_H: if (bus.stk_rdy) begin
                    pch_q <= bus.stk_rdata;
                    sp_q  <= sp_dec;
                end
                POP_L: if (bus.stk_rdy) begin
                    pcl_q <= bus.stk_rdata;
                    sp_q  <= sp_dec;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ack       = 1'b0;
        bus.reti      = 1'b0;
        bus.stall     = !boundary;
        bus.pc_ld     = 1'b0;
        bus.pc_out    = 16'h0000;
        bus.stk_we    = 1'b0;
        bus.stk_re    = 1'b0;
        bus.stk_addr  = 8'h00;
        bus.stk_wdata = 8'h00;
        bus.sp_we     = 1'b0;
        bus.sp_out    = 8'h00;
        case (state_q)
            ACK: bus.ack = 1'b1;
            PUSH_L, PUSH_H: begin
                bus.stk_we    = 1'b1;
                bus.stk_addr  = sp_inc;
                bus.stk_wdata = (state_q == PUSH_L) ? pc_q[7:0] : pc_q[15:8];
                bus.sp_out    = sp_inc;
                bus.sp_we     = bus.stk_rdy;
            end
            LOAD: begin
                bus.pc_ld  = 1'b1;
                bus.pc_out = {8'h00, vec_q};
            end
            POP_H, POP_L: begin
                bus.stk_re   = 1'b1;
                bus.stk_addr = sp_q;
                bus.sp_out   = sp_dec;
                bus.sp_we    = bus.stk_rdy;
            end
            RET: begin
                bus.pc_ld  = 1'b1;
                bus.reti   = 1'b1;
                bus.pc_out = {pch_q, pcl_q};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_oc8051_int_seq.sv
// Bench for oc8051_int_seq: directed scenarios plus randomized entry/RETI round trips against a stack model.
module tb_oc8051_int_seq;
    logic clk;
    logic rst;

    oc8051_int_seq_if bus ();
    oc8051_int_seq dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int first_stall = -1;
    int ack_q[$], reti_q[$], pcld_c[$], pcld_v[$], wr_a[$], wr_d[$], spw_q[$];
    logic [7:0] mem [256];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic drive(input logic i_intr, input logic [7:0] i_vec, input logic i_ie,
                         input logic i_reti, input logic i_rdy);
        bus.intr       = i_intr;
        bus.int_vec    = i_vec;
        bus.instr_end  = i_ie;
        bus.reti_instr = i_reti;
        bus.stk_rdy    = i_rdy;
    endtask

    // One clock: observe at the falling edge, act as stack RAM and SP register, then advance.
    task automatic step();
        @(negedge clk);
        if (bus.ack)   ack_q.push_back(cyc - t0);
        if (bus.reti)  reti_q.push_back(cyc - t0);
        if (bus.pc_ld) begin
            pcld_c.push_back(cyc - t0);
            pcld_v.push_back(int'(bus.pc_out));
        end
        if (bus.stall && first_stall < 0) first_stall = cyc - t0;
        if (bus.stk_we && bus.stk_rdy) begin
            mem[bus.stk_addr] = bus.stk_wdata;
            wr_a.push_back(int'(bus.stk_addr));
            wr_d.push_back(int'(bus.stk_wdata));
        end
        if (bus.sp_we) begin
            spw_q.push_back(int'(bus.sp_out));
            bus.sp = bus.sp_out;
        end
        bus.stk_rdata = mem[bus.stk_addr];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start();
        ack_q.delete(); reti_q.delete(); pcld_c.delete(); pcld_v.delete();
        wr_a.delete(); wr_d.delete(); spw_q.delete();
        first_stall = -1;
        t0 = cyc;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ack"},   int'(bus.ack),       0);
        chk({tag, "_reti"},  int'(bus.reti),      0);
        chk({tag, "_stall"}, int'(bus.stall),     0);
        chk({tag, "_pcld"},  int'(bus.pc_ld),     0);
        chk({tag, "_pcout"}, int'(bus.pc_out),    0);
        chk({tag, "_we"},    int'(bus.stk_we),    0);
        chk({tag, "_re"},    int'(bus.stk_re),    0);
        chk({tag, "_addr"},  int'(bus.stk_addr),  0);
        chk({tag, "_wdata"}, int'(bus.stk_wdata), 0);
        chk({tag, "_spwe"},  int'(bus.sp_we),     0);
        chk({tag, "_spout"}, int'(bus.sp_out),    0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s, v, a1, a2;
        logic [15:0] p;
        int          d;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.pc = 16'h0000;
        bus.sp = 8'h00;
        bus.stk_rdata = 8'h00;
        #2;
        chk_outs_zero("reset");
        step();
        step();
        rst = 1'b1;

        // Basic entry
        bus.sp = 8'h07; bus.pc = 16'h1234; start();
        for (int i = 0; i < 8; i++) begin drive(i == 0, 8'h0B, 1'b1, 1'b0, 1'b1); step(); end
        chk("t1_ack_n",   ack_q.size(), 1);
        chk("t1_ack_cyc", qat(ack_q, 0), 2);
        chk("t1_stall0",  first_stall, 2);
        chk("t1_wr0_a",   qat(wr_a, 0), 'h08);
        chk("t1_wr0_d",   qat(wr_d, 0), 'h34);
        chk("t1_wr1_a",   qat(wr_a, 1), 'h09);
        chk("t1_wr1_d",   qat(wr_d, 1), 'h12);
        chk("t1_sp0",     qat(spw_q, 0), 'h08);
        chk("t1_sp1",     qat(spw_q, 1), 'h09);
        chk("t1_pcld_n",  pcld_c.size(), 1);
        chk("t1_pcld_c",  qat(pcld_c, 0), 5);
        chk("t1_pcld_v",  qat(pcld_v, 0), 'h000B);
        chk("t1_idle_st", int'(bus.stall), 0);

        // Boundary wait: instr_end first high in cycle 6
        bus.sp = 8'h40; bus.pc = 16'h0100; start();
        for (int i = 0; i < 14; i++) begin drive(i == 0, 8'h23, i >= 6, 1'b0, 1'b1); step(); end
        chk("t2_ack_n",   ack_q.size(), 1);
        chk("t2_ack_cyc", qat(ack_q, 0), 7);
        chk("t2_stall0",  first_stall, 7);
        chk("t2_pcld_c",  qat(pcld_c, 0), 10);
        chk("t2_pcld_v",  qat(pcld_v, 0), 'h0023);

        // RETI
        bus.sp = 8'h09; mem[9] = 8'h12; mem[8] = 8'h34; start();
        for (int i = 0; i < 6; i++) begin drive(1'b0, 8'h00, 1'b0, i == 0, 1'b1); step(); end
        chk("t3_pcld_c",  qat(pcld_c, 0), 3);
        chk("t3_pcld_v",  qat(pcld_v, 0), 'h1234);
        chk("t3_reti_n",  reti_q.size(), 1);
        chk("t3_reti_c",  qat(reti_q, 0), 3);
        chk("t3_sp0",     qat(spw_q, 0), 'h08);
        chk("t3_sp1",     qat(spw_q, 1), 'h07);
        chk("t3_stall0",  first_stall, 1);
        chk("t3_sp_fin",  int'(bus.sp), 'h07);

        // Inhibit: intr during POP_H is held until a full instr_end after RET
        bus.sp = 8'h09; mem[9] = 8'h20; mem[8] = 8'h00; bus.pc = 16'h5566; start();
        for (int i = 0; i < 16; i++) begin
            drive(i == 1, 8'h03, (i == 6) || (i >= 8), i == 0, 1'b1);
            step();
        end
        chk("t4_reti_c",  qat(reti_q, 0), 3);
        chk("t4_ret_v",   qat(pcld_v, 0), 'h2000);
        chk("t4_ack_n",   ack_q.size(), 1);
        chk("t4_ack_cyc", qat(ack_q, 0), 9);
        chk("t4_pcld_c",  qat(pcld_c, 1), 12);
        chk("t4_pcld_v",  qat(pcld_v, 1), 'h0003);
        chk("t4_wr0_d",   qat(wr_d, 0), 'h66);
        chk("t4_wr1_a",   qat(wr_a, 1), 'h09);
        chk("t4_wr1_d",   qat(wr_d, 1), 'h55);

        // Wait states in PUSH_L and SP wrap
        bus.sp = 8'hFF; bus.pc = 16'hABCD; start();
        for (int i = 0; i < 12; i++) begin
            drive(i == 0, 8'h13, 1'b1, 1'b0, !(i >= 3 && i <= 5));
            if (i >= 3 && i <= 5) begin
                #1;
                chk("t5_we_hold",   int'(bus.stk_we), 1);
                chk("t5_addr_hold", int'(bus.stk_addr), 'h00);
                chk("t5_wd_hold",   int'(bus.stk_wdata), 'hCD);
                chk("t5_spwe_low",  int'(bus.sp_we), 0);
            end
            step();
        end
        chk("t5_wr0_a",  qat(wr_a, 0), 'h00);
        chk("t5_wr0_d",  qat(wr_d, 0), 'hCD);
        chk("t5_wr1_a",  qat(wr_a, 1), 'h01);
        chk("t5_wr1_d",  qat(wr_d, 1), 'hAB);
        chk("t5_sp0",    qat(spw_q, 0), 'h00);
        chk("t5_sp1",    qat(spw_q, 1), 'h01);
        chk("t5_pcld_c", qat(pcld_c, 0), 8);
        chk("t5_pcld_v", qat(pcld_v, 0), 'h0013);

        // Reset while in PUSH_H
        bus.sp = 8'h10; bus.pc = 16'h7777; start();
        for (int i = 0; i < 5; i++) begin
            drive(i == 0, 8'h2B, 1'b1, 1'b0, i != 4);
            if (i == 4) begin
                #1;
                chk("t6_pre_we", int'(bus.stk_we), 1);
                rst = 1'b0;
                #1;
                chk_outs_zero("t6_mid");
            end
            step();
        end
        step();
        rst = 1'b1;
        start();
        for (int i = 0; i < 10; i++) begin drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); step(); end
        chk("t6_no_ack",   ack_q.size(), 0);
        chk("t6_no_pcld",  pcld_c.size(), 0);
        chk("t6_no_stall", first_stall, -1);
        bus.sp = 8'h20; start();
        for (int i = 0; i < 8; i++) begin drive(i == 0, 8'h33, 1'b1, 1'b0, 1'b1); step(); end
        chk("t6_new_ack",  qat(ack_q, 0), 2);
        chk("t6_new_vec",  qat(pcld_v, 0), 'h0033);

        // Randomized entry + RETI round trips with random wait states
        for (int it = 0; it < 25; it++) begin
            s = 8'($urandom); p = 16'($urandom); v = 8'($urandom);
            d = int'($urandom_range(0, 4));
            a1 = s + 8'd1; a2 = s + 8'd2;
            for (int i = 0; i < 2; i++) begin drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); step(); end
            bus.sp = s; bus.pc = p; start();
            for (int i = 0; i < 60 && pcld_c.size() == 0; i++) begin
                drive(i == 0, v, i > d, 1'b0, $urandom_range(0, 3) != 0);
                step();
            end
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            chk("rnd_ack_n",   ack_q.size(), 1);
            chk("rnd_ack_cyc", qat(ack_q, 0), d + 2);
            chk("rnd_vec",     qat(pcld_v, 0), int'(v));
            chk("rnd_push_l",  int'(mem[a1]), int'(p[7:0]));
            chk("rnd_push_h",  int'(mem[a2]), int'(p[15:8]));
            chk("rnd_sp_ent",  int'(bus.sp), int'(a2));
            start();
            for (int i = 0; i < 60 && pcld_c.size() == 0; i++) begin
                drive(1'b0, 8'h00, 1'b0, i == 0, $urandom_range(0, 3) != 0);
                step();
            end
            chk("rnd_reti_n",  reti_q.size(), 1);
            chk("rnd_ret_pc",  qat(pcld_v, 0), int'(p));
            chk("rnd_sp_ret",  int'(bus.sp), int'(s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/oc8051_int_seq.md
# oc8051_int_seq

Interrupt acceptance sequencer on the CPU side of the interrupt controller. It latches the one-cycle vector pulse from the controller and waits for an instruction boundary. It then acknowledges the controller, pushes the return PC (low byte, then high byte) onto the internal-RAM stack, and loads the PC with the vector. On RETI it pops the PC and signals the controller so it can restore the previous priority level.

## Interface
No parameters.
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- intr  input  1  controller interrupt request pulse (high for exactly the cycle int_vec is valid)
- int_vec  input  8  vector address from controller, valid while intr=1
- instr_end  input  1  high in the last cycle of the currently executing instruction
- reti_instr  input  1  one-cycle pulse from decoder when a RETI executes
- pc  input  16  PC of the next instruction (return address)
- sp  input  8  current stack pointer SFR value
- stk_rdy  input  1  stack RAM access complete this cycle
- stk_rdata  input  8  stack RAM read data, valid with stk_rdy during a read
- ack  output  1  one-cycle acknowledge to controller (clears the edge flag of the serviced source)
- reti  output  1  one-cycle return-from-interrupt pulse to controller
- stall  output  1  holds core fetch/execute while the sequencer owns PC and stack
- pc_ld  output  1  one-cycle PC load strobe
- pc_out  output  16  PC load value
- stk_we, stk_re  output  1  stack RAM write/read request
- stk_addr  output  8  stack RAM address
- stk_wdata  output  8  stack RAM write data
- sp_we  output  1  SP SFR write strobe
- sp_out  output  8  new SP value

## Operation
- States: IDLE, PEND, ACK, PUSH_L, PUSH_H, LOAD, POP_H, POP_L, RET.
- Vector latch:
  - intr=1 in any state stores int_vec into vec_q and sets pend.
  - A second pulse while pend=1 overwrites vec_q. This is a level-1 preemption and is intentional.
  - pend clears on entering ACK.
- IDLE -> PEND when pend is set, or when intr=1.
- PEND -> ACK on instr_end=1 with inhibit=0.
- ACK:
  - ack=1 and stall=1.
  - Capture pc_q<=pc and sp_q<=sp.
  - -> PUSH_L.
- PUSH_L:
  - stk_we=1, stk_addr=sp_q+1, stk_wdata=pc_q[7:0].
  - On stk_rdy: sp_we=1, sp_out=sp_q+1, sp_q<=sp_q+1, -> PUSH_H.
- PUSH_H: same as PUSH_L with pc_q[15:8]; on stk_rdy -> LOAD.
- LOAD: pc_ld=1, pc_out={8'h00,vec_q}, -> IDLE.
- RETI path:
  - reti_instr in IDLE or PEND: capture sp_q<=sp, -> POP_H. A pending request stays pending.
  - POP_H: stk_re=1, stk_addr=sp_q. On stk_rdy: pch<=stk_rdata, sp_q-1 written via sp_we, -> POP_L.
  - POP_L: same read at sp_q; pcl<=stk_rdata, -> RET.
  - RET: pc_ld=1, pc_out={pch,pcl}, reti=1, inhibit<=1, -> PEND if pend else IDLE.
- inhibit clears on the next instr_end while in IDLE/PEND. This guarantees one instruction executes after RETI before another interrupt is taken.
- stall=1 in every state except IDLE and PEND.
- SP arithmetic is 8-bit modulo 256: 8'hFF+1 -> 8'h00 and 8'h00-1 -> 8'hFF. No overflow flag.
- Boundary conditions:
  - stk_rdy=0: remain in state with all request outputs stable.
  - reti_instr during ACK..LOAD is ignored. The core is stalled, so this cannot legally occur.
  - intr and reti_instr in the same cycle: the vector is latched and the RETI path is taken first.
- Reset mid-operation: immediate return to IDLE; pend, inhibit and vec_q cleared; any partial push/pop is abandoned.

## Timing
- Reset values: every output 0 (ack, reti, stall, pc_ld, stk_we, stk_re, sp_we = 0; pc_out, stk_addr, stk_wdata, sp_out = 0).
- All outputs are decoded from registered state and registered data. No input-to-output combinational path exists except stk_rdy gating sp_we.
- Entry latency, with stk_rdy tied 1 and instr_end=1: intr at cycle 0 gives PEND at 1, ack at 2, PUSH_L at 3, PUSH_H at 4, pc_ld at 5.
- Each stack access takes 1 cycle plus the number of cycles stk_rdy is held low.
- RETI latency: reti_instr at cycle 0 gives POP_H at 1, POP_L at 2, pc_ld and reti at 3 (stk_rdy=1).

## Test plan
- Basic entry:
  - Stimulus: sp=8'h07, pc=16'h1234, intr with int_vec=8'h0B, instr_end=1.
  - Response: ack at cycle 2; writes 8'h34 at addr 8'h08 and 8'h12 at addr 8'h09; sp_out 8'h08 then 8'h09; pc_ld with 16'h000B at cycle 5.
- Boundary wait:
  - Stimulus: intr at cycle 0, instr_end low until cycle 6.
  - Response: ack exactly at cycle 7; stall=0 through cycle 6.
- RETI:
  - Stimulus: sp=8'h09, RAM[9]=8'h12, RAM[8]=8'h34, reti_instr pulse.
  - Response: pc_out=16'h1234 with pc_ld and reti at cycle 3; sp_out 8'h08 then 8'h07.
- Inhibit after RETI:
  - Stimulus: intr with vector 8'h03 during POP_H.
  - Response: the pending request is not acked until one full instruction_end has passed after RET.
- Wait states and wrap:
  - Stimulus: sp=8'hFF, stk_rdy low for 3 cycles in PUSH_L.
  - Response: stk_addr stays 8'h00 with stable data; sp_out=8'h00 then 8'h01.
- Reset during PUSH_H:
  - Stimulus: assert rst=0 while in PUSH_H.
  - Response: all outputs 0 immediately; no ack or pc_ld after release until a new intr arrives.
